// File: rtl/adc_multi_pkg.sv
// Shared types and constants for the multi-channel serial-ADC monitor.
package adc_multi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StConvert,
      StSckHigh,
      StSckLow,
      StDone
   } state_e;

   localparam int unsigned MAX_CH    = 8;
   localparam int unsigned SEL_W     = $clog2(MAX_CH);
   // Limits come out of reset fully open; sliced to OUT_W at the use site.
   localparam logic [31:0] LIMIT_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/adc_multi_monitor_if.sv
// Register-side bus of the ADC monitor: limit writes, status clear, published samples and flags.
interface adc_multi_monitor_if #(
   parameter int unsigned N_CH  = 2,
   parameter int unsigned OUT_W = 16
);
   import adc_multi_pkg::*;

   logic                    limit_wr;
   logic [SEL_W-1:0]        limit_sel;
   logic [OUT_W-1:0]        limit_data;
   logic                    status_clear;
   logic                    sample_valid;
   logic [N_CH*OUT_W-1:0]   sample_data;
   logic [N_CH-1:0]         limit_fail;
   logic [N_CH-1:0]         limit_sticky;
   logic                    irq;

   modport master (
      output limit_wr, limit_sel, limit_data, status_clear,
      input  sample_valid, sample_data, limit_fail, limit_sticky, irq
   );

   modport slave (
      input  limit_wr, limit_sel, limit_data, status_clear,
      output sample_valid, sample_data, limit_fail, limit_sticky, irq
   );

endinterface

// File: rtl/adc_limit_checker.sv
// Per-channel limit register, strict unsigned over-limit compare, live and sticky fail flags.
module adc_limit_checker
   import adc_multi_pkg::*;
#(
   parameter int unsigned CH    = 0,
   parameter int unsigned OUT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             sample_valid,
   input  logic [OUT_W-1:0] sample,
   input  logic             limit_wr,
   input  logic [SEL_W-1:0] limit_sel,
   input  logic [OUT_W-1:0] limit_data,
   input  logic             status_clear,
   output logic             fail,
   output logic             sticky
);

   logic [OUT_W-1:0] limit_q;
   logic             fail_q;
   logic             sticky_q;
   logic             set;

   // Compares against the pre-write limit when a write lands on the same edge.
   assign set = sample_valid && (sample > limit_q);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         limit_q  <= LIMIT_RST[OUT_W-1:0];
         fail_q   <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         if (limit_wr && (32'(limit_sel) == CH)) limit_q <= limit_data;
         if (sample_valid) fail_q <= set;
         if (set) sticky_q <= 1'b1;
         else if (status_clear) sticky_q <= 1'b0;
      end
   end

   assign fail   = fail_q;
   assign sticky = sticky_q;

endmodule

// File: rtl/adc_multi_monitor.sv
// Serial-ADC front end: shared convert/sck sequencing, MSB-first capture and per-channel limits.
module adc_multi_monitor
   import adc_multi_pkg::*;
#(
   parameter int unsigned N_CH     = 2,
   parameter int unsigned DATA_W   = 14,
   parameter int unsigned OUT_W    = 16,
   parameter int unsigned CONV_CYC = 21,
   parameter int unsigned SCK_DIV  = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                enable,
   input  logic [N_CH-1:0]     adc_sdo,
   output logic                adc_convert,
   output logic                adc_sck,
   adc_multi_monitor_if.slave  bus
);

   localparam int unsigned CNT_MAX = (CONV_CYC > SCK_DIV) ? CONV_CYC : SCK_DIV;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

   state_e                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [BIT_W-1:0]             bit_q, bit_d;
   logic                         shift_en;
   logic                         frame_done;
   logic [N_CH-1:0][DATA_W-1:0]  shreg_q;
   logic [N_CH*OUT_W-1:0]        data_q;
   logic                         valid_q;
   logic [N_CH-1:0]              fail;
   logic [N_CH-1:0]              sticky;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StConvert;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         StConvert: begin
            if (cnt_q == CNT_W'(CONV_CYC - 1)) begin
               cnt_d   = '0;
               state_d = StSckHigh;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StSckHigh: begin
            if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
               cnt_d    = '0;
               shift_en = 1'b1;
               bit_d    = bit_q + BIT_W'(1);
               state_d  = StSckLow;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StSckLow: begin
            if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
               cnt_d = '0;
               if (bit_q == BIT_W'(DATA_W)) begin
                  state_d    = StDone;
                  frame_done = 1'b1;
               end else begin
                  state_d = StSckHigh;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         valid_q <= frame_done;
         for (int k = 0; k < int'(N_CH); k++) begin
            if (shift_en) shreg_q[k] <= (shreg_q[k] << 1) | DATA_W'(adc_sdo[k]);
            if (frame_done) data_q[k*OUT_W +: OUT_W] <= OUT_W'(shreg_q[k]);
         end
      end
   end

   // Convert is high for the IDLE launch cycle plus all but the last CONVERT cycle, so the
   // strobe lasts CONV_CYC cycles and one low cycle separates it from the first sck rise.
   assign adc_convert = rstn && (((state_q == StIdle) && enable) ||
                                 ((state_q == StConvert) && (cnt_q != CNT_W'(CONV_CYC - 1))));
   assign adc_sck     = (state_q == StSckHigh);

   for (genvar k = 0; k < N_CH; k++) begin : g_chk
      adc_limit_checker #(
         .CH    (k),
         .OUT_W (OUT_W)
      ) u_chk (
         .clk          (clk),
         .rstn         (rstn),
         .sample_valid (valid_q),
         .sample       (data_q[k*OUT_W +: OUT_W]),
         .limit_wr     (bus.limit_wr),
         .limit_sel    (bus.limit_sel),
         .limit_data   (bus.limit_data),
         .status_clear (bus.status_clear),
         .fail         (fail[k]),
         .sticky       (sticky[k])
      );
   end

   assign bus.sample_valid = valid_q;
   assign bus.sample_data  = data_q;
   assign bus.limit_fail   = fail;
   assign bus.limit_sticky = sticky;
   assign bus.irq          = |sticky;

endmodule
